// File: rtl/ipg_pkg.sv
// Shared constants and types for the IPG slot scheduler.
package ipg_pkg;

   localparam logic [7:0] IDLE_BLOCK_TYPE = 8'h1E;
   localparam logic [1:0] CTRL_HDR        = 2'b10;

   typedef enum logic {
      TURN_REPLY = 1'b0,
      TURN_REQ   = 1'b1
   } ipg_turn_t;

   typedef enum logic {
      SRC_REPLY = 1'b0,
      SRC_REQ   = 1'b1
   } ipg_src_t;

endpackage

// File: rtl/ipg_slot_sched_if.sv
// Bus bundle between the chunk queues, the encoder tap and the IPG insertion mux.
interface ipg_slot_sched_if
   import ipg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned HDR_WIDTH  = 2
);
   logic [DATA_WIDTH-1:0] encoded_tx_data;
   logic [HDR_WIDTH-1:0]  encoded_tx_hdr;
   logic                  reply_valid;
   logic [DATA_WIDTH-1:0] reply_chunk;
   logic                  reply_ready;
   logic                  req_valid;
   logic [DATA_WIDTH-1:0] req_chunk;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] ipg_chunk;
   logic                  ipg_chunk_valid;
   ipg_src_t              ipg_chunk_src;
   logic                  tx_pause;

   modport master (
      output encoded_tx_data, encoded_tx_hdr,
      output reply_valid, reply_chunk, req_valid, req_chunk,
      input  reply_ready, req_ready,
      input  ipg_chunk, ipg_chunk_valid, ipg_chunk_src, tx_pause
   );

   modport slave (
      input  encoded_tx_data, encoded_tx_hdr,
      input  reply_valid, reply_chunk, req_valid, req_chunk,
      output reply_ready, req_ready,
      output ipg_chunk, ipg_chunk_valid, ipg_chunk_src, tx_pause
   );
endinterface

// File: rtl/ipg_wait_age.sv
// Saturating wait-age counter for one chunk source with a threshold flag.
module ipg_wait_age #(
   parameter int unsigned PAUSE_THRESH = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic granted,
   output logic aged
);
   logic [15:0] age_q, age_d;

   always_comb begin
      if (granted || !valid) begin
         age_d = '0;
      end else if (age_q == 16'hFFFF) begin
         age_d = age_q;
      end else begin
         age_d = age_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   // Flag from the next age so the registered pause drops right after a grant.
   assign aged = (32'(age_d) >= PAUSE_THRESH);

endmodule

// File: rtl/ipg_slot_sched.sv
// Weighted round-robin scheduler of reply/request chunks into idle 64b/66b slots.
// Optional statistics counters are enabled by defining IPG_SLOT_SCHED_STATS_EN.
module ipg_slot_sched
   import ipg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned HDR_WIDTH    = 2,
   parameter int unsigned REPLY_WEIGHT = 3,
   parameter int unsigned REQ_WEIGHT   = 1,
   parameter int unsigned PAUSE_THRESH = 64
) (
   input  logic              clk,
   input  logic              rst,
   ipg_slot_sched_if.slave   bus
`ifdef IPG_SLOT_SCHED_STATS_EN
   ,
   output logic [31:0]       stat_slots,
   output logic [31:0]       stat_reply_grants,
   output logic [31:0]       stat_req_grants,
   output logic [31:0]       stat_wasted
`endif
);
   localparam logic [3:0] REPLY_W = 4'(REPLY_WEIGHT);
   localparam logic [3:0] REQ_W   = 4'(REQ_WEIGHT);

   ipg_turn_t             turn_q, turn_d;
   logic [3:0]            credit_q, credit_d;
   logic                  slot;
   logic                  grant_reply, grant_req;
   logic [DATA_WIDTH-1:0] chunk_q;
   logic                  chunk_valid_q;
   ipg_src_t              src_q;
   logic                  pause_q;
   logic                  reply_aged, req_aged;

   assign slot = (bus.encoded_tx_hdr == HDR_WIDTH'(CTRL_HDR))
              && (bus.encoded_tx_data[7:0] == IDLE_BLOCK_TYPE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turn_q   <= TURN_REPLY;
         credit_q <= REPLY_W;
      end else begin
         turn_q   <= turn_d;
         credit_q <= credit_d;
      end
   end

   // Next state: a borrowed slot does not consume the owner's credit
   always_comb begin
      turn_d   = turn_q;
      credit_d = credit_q;
      unique case (turn_q)
         TURN_REPLY: begin
            if (grant_reply) begin
               if (credit_q <= 4'd1) begin
                  turn_d   = TURN_REQ;
                  credit_d = REQ_W;
               end else begin
                  credit_d = credit_q - 4'd1;
               end
            end else if (grant_req) begin
               if (REQ_W <= 4'd1) begin
                  turn_d   = TURN_REPLY;
                  credit_d = REPLY_W;
               end else begin
                  turn_d   = TURN_REQ;
                  credit_d = REQ_W - 4'd1;
               end
            end
         end
         TURN_REQ: begin
            if (grant_req) begin
               if (credit_q <= 4'd1) begin
                  turn_d   = TURN_REPLY;
                  credit_d = REPLY_W;
               end else begin
                  credit_d = credit_q - 4'd1;
               end
            end else if (grant_reply) begin
               if (REPLY_W <= 4'd1) begin
                  turn_d   = TURN_REQ;
                  credit_d = REQ_W;
               end else begin
                  turn_d   = TURN_REPLY;
                  credit_d = REPLY_W - 4'd1;
               end
            end
         end
         default: ;
      endcase
   end

   // Grant decode; gated by rst so no chunk is popped while held in reset
   always_comb begin
      grant_reply = 1'b0;
      grant_req   = 1'b0;
      if (slot && !rst) begin
         unique case (turn_q)
            TURN_REPLY: begin
               if (bus.reply_valid)    grant_reply = 1'b1;
               else if (bus.req_valid) grant_req   = 1'b1;
            end
            TURN_REQ: begin
               if (bus.req_valid)        grant_req   = 1'b1;
               else if (bus.reply_valid) grant_reply = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.reply_ready = grant_reply;
   assign bus.req_ready   = grant_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chunk_q       <= '0;
         chunk_valid_q <= 1'b0;
         src_q         <= SRC_REPLY;
         pause_q       <= 1'b0;
      end else begin
         chunk_valid_q <= grant_reply | grant_req;
         pause_q       <= reply_aged | req_aged;
         if (grant_reply) begin
            chunk_q <= bus.reply_chunk;
            src_q   <= SRC_REPLY;
         end else if (grant_req) begin
            chunk_q <= bus.req_chunk;
            src_q   <= SRC_REQ;
         end
      end
   end

   assign bus.ipg_chunk       = chunk_q;
   assign bus.ipg_chunk_valid = chunk_valid_q;
   assign bus.ipg_chunk_src   = src_q;
   assign bus.tx_pause        = pause_q;

   ipg_wait_age #(
      .PAUSE_THRESH (PAUSE_THRESH)
   ) u_age_reply (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.reply_valid),
      .granted (grant_reply),
      .aged    (reply_aged)
   );

   ipg_wait_age #(
      .PAUSE_THRESH (PAUSE_THRESH)
   ) u_age_req (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.req_valid),
      .granted (grant_req),
      .aged    (req_aged)
   );

`ifdef IPG_SLOT_SCHED_STATS_EN
   logic [31:0] slots_q, reply_grants_q, req_grants_q, wasted_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots_q        <= '0;
         reply_grants_q <= '0;
         req_grants_q   <= '0;
         wasted_q       <= '0;
      end else begin
         if (slot)        slots_q        <= slots_q + 32'd1;
         if (grant_reply) reply_grants_q <= reply_grants_q + 32'd1;
         if (grant_req)   req_grants_q   <= req_grants_q + 32'd1;
         if (slot && !bus.reply_valid && !bus.req_valid) wasted_q <= wasted_q + 32'd1;
      end
   end

   assign stat_slots        = slots_q;
   assign stat_reply_grants = reply_grants_q;
   assign stat_req_grants   = req_grants_q;
   assign stat_wasted       = wasted_q;
`endif

endmodule

// File: tb/tb_ipg_slot_sched.sv
// Scoreboard bench for ipg_slot_sched: directed slot patterns, pause aging, reset and stats.
module tb_ipg_slot_sched;
   import ipg_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ipg_slot_sched_if bus ();

`ifdef IPG_SLOT_SCHED_STATS_EN
   logic [31:0] stat_slots, stat_reply_grants, stat_req_grants, stat_wasted;
`endif

   ipg_slot_sched #(
      .DATA_WIDTH   (64),
      .HDR_WIDTH    (2),
      .REPLY_WEIGHT (3),
      .REQ_WEIGHT   (1),
      .PAUSE_THRESH (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef IPG_SLOT_SCHED_STATS_EN
      ,
      .stat_slots        (stat_slots),
      .stat_reply_grants (stat_reply_grants),
      .stat_req_grants   (stat_req_grants),
      .stat_wasted       (stat_wasted)
`endif
   );

   int checks = 0;
   int failures = 0;
   int seq = 0;
   logic [64:0] exp_q[$];  // {src, chunk}

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // exp_g: -1 no grant, 0 reply, 1 request. exp_pause: 0/1, or 2 to skip.
   task automatic cyc(input logic [1:0] hdr, input logic [7:0] btype, input logic rv,
                      input logic qv, input int exp_g, input int exp_pause);
      logic [63:0] rc, qc;
      rc = 64'hAAAA_0000_0000_0000 | 64'(seq);
      qc = 64'h5555_0000_0000_0000 | 64'(seq);
      @(posedge clk);
      #1;
      bus.encoded_tx_hdr  = hdr;
      bus.encoded_tx_data = {56'(seq), btype};
      bus.reply_valid     = rv;
      bus.reply_chunk     = rc;
      bus.req_valid       = qv;
      bus.req_chunk       = qc;
      #3;
      chk("reply_ready", 64'(bus.reply_ready), 64'(exp_g == 0));
      chk("req_ready", 64'(bus.req_ready), 64'(exp_g == 1));
      if (exp_pause != 2) chk("tx_pause", 64'(bus.tx_pause), 64'(exp_pause == 1));
      if (exp_g == 0) exp_q.push_back({1'b0, rc});
      if (exp_g == 1) exp_q.push_back({1'b1, qc});
      seq++;
   endtask

   task automatic gap();
      cyc(2'b01, 8'h00, 1'b0, 1'b0, -1, 2);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_reply_ready"}, 64'(bus.reply_ready), 64'd0);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, "_chunk_valid"}, 64'(bus.ipg_chunk_valid), 64'd0);
      chk({tag, "_chunk"}, bus.ipg_chunk, 64'd0);
      chk({tag, "_src"}, 64'(bus.ipg_chunk_src), 64'd0);
      chk({tag, "_tx_pause"}, 64'(bus.tx_pause), 64'd0);
   endtask

   // Monitor: every presented chunk must match the oldest expected grant
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge clk);
         if (bus.ipg_chunk_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant: got src=%0d chunk=%0h expected none (t=%0t)",
                        bus.ipg_chunk_src, bus.ipg_chunk, $time);
            end else begin
               e = exp_q.pop_front();
               chk("grant_src", 64'(bus.ipg_chunk_src), 64'(e[64]));
               chk("grant_chunk", bus.ipg_chunk, e[63:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a live slot and both sources valid: nothing may be popped
      rst = 1'b1;
      bus.encoded_tx_hdr  = CTRL_HDR;
      bus.encoded_tx_data = {56'h0, IDLE_BLOCK_TYPE};
      bus.reply_valid     = 1'b1;
      bus.reply_chunk     = 64'h1;
      bus.req_valid       = 1'b1;
      bus.req_chunk       = 64'h2;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.encoded_tx_hdr = 2'b01;
      bus.reply_valid    = 1'b0;
      bus.req_valid      = 1'b0;

      // Weighted round robin 3/1, both always valid: R,R,R,Q,R,R,R,Q
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 1, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 1, 0);
      gap();

      // Data blocks only: reply waits 100 cycles, pause after 64 waiting cycles
      for (int i = 0; i < 100; i++) begin
         cyc(2'b01, 8'h1E, 1, 0, -1, (i >= 64) ? 1 : 0);
      end
      cyc(2'b10, 8'h1E, 1, 0, 0, 1);
      cyc(2'b01, 8'h00, 0, 0, -1, 0);

      // Request-only while reply holds the turn, then the round resumes
      cyc(2'b10, 8'h1E, 0, 1, 1, 0);
      cyc(2'b10, 8'h1E, 0, 1, 1, 0);
      cyc(2'b10, 8'h1E, 0, 1, 1, 0);
      cyc(2'b10, 8'h1E, 0, 1, 1, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 1, 0);
      gap();

      // Non-slot blocks: start control, idle type under data/invalid headers
      cyc(2'b10, 8'h33, 1, 1, -1, 0);
      cyc(2'b01, 8'h1E, 1, 1, -1, 0);
      cyc(2'b11, 8'h1E, 1, 1, -1, 0);
      gap();

      // Reset mid-stream with credit partly used; credit must reload to 3
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      gap();
      @(posedge clk);
      #1;
      bus.encoded_tx_hdr  = CTRL_HDR;
      bus.encoded_tx_data = {56'h0, IDLE_BLOCK_TYPE};
      bus.reply_valid     = 1'b1;
      bus.req_valid       = 1'b1;
      #1;
      rst = 1'b1;
      #2;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.encoded_tx_hdr = 2'b01;
      bus.reply_valid    = 1'b0;
      bus.req_valid      = 1'b0;
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 0, 0);
      cyc(2'b10, 8'h1E, 1, 1, 1, 0);
      gap();

      // Statistics run from a fresh reset: 10 slots, 4 reply, 3 request, 3 wasted
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(2'b10, 8'h1E, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(2'b10, 8'h1E, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) cyc(2'b10, 8'h1E, 0, 0, -1, 0);
      cyc(2'b01, 8'h1E, 1, 1, -1, 0);
      gap();
`ifdef IPG_SLOT_SCHED_STATS_EN
      chk("stat_slots", 64'(stat_slots), 64'd10);
      chk("stat_reply_grants", 64'(stat_reply_grants), 64'd4);
      chk("stat_req_grants", 64'(stat_req_grants), 64'd3);
      chk("stat_wasted", 64'(stat_wasted), 64'd3);
`endif

      gap();
      gap();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ipg_slot_sched.md
# ipg_slot_sched

Per-slot scheduler sharing the idle-block slots of the 10G PHY TX encoded stream between two IPG message sources: the reply queue (memory responses) and the request queue (remote requests). It sits between the two chunk queues and the IPG insertion datapath, immediately after the 64b/66b encoder. Each cycle it decides whether the current 66-bit block is an insertable idle slot, picks one source by weighted round-robin and presents the winning chunk registered. It asserts `tx_pause` to the MAC when a source has waited too long for a slot.

## Interface
- `DATA_WIDTH`, 64, block/chunk width; only 64 is legal.
- `HDR_WIDTH`, 2, sync header width; only 2 is legal.
- `REPLY_WEIGHT`, 3, consecutive reply grants per round, 1..15.
- `REQ_WEIGHT`, 1, consecutive request grants per round, 1..15.
- `PAUSE_THRESH`, 64, wait cycles before `tx_pause`, 1..65535.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `encoded_tx_data`  in  64  encoder output block.
- `encoded_tx_hdr`  in  2  encoder output sync header.
- `reply_valid`  in  1  reply chunk available.
- `reply_chunk`  in  64  head reply chunk.
- `reply_ready`  out  1  reply chunk consumed this cycle (combinational).
- `req_valid`  in  1  request chunk available.
- `req_chunk`  in  64  head request chunk.
- `req_ready`  out  1  request chunk consumed this cycle (combinational).
- `ipg_chunk`  out  64  granted chunk, registered.
- `ipg_chunk_valid`  out  1  `ipg_chunk` replaces the aligned idle block.
- `ipg_chunk_src`  out  1  0 = reply, 1 = request.
- `tx_pause`  out  1  MAC should insert idle blocks.

## Operation
- Slot: `slot = (encoded_tx_hdr == 2'b10) && (encoded_tx_data[7:0] == 8'h1E)`. Only all-idle control blocks qualify.
- FSM states: `TURN_REPLY`, `TURN_REQ`. There is a 4-bit credit counter.
- On a slot in `TURN_REPLY`:
  - If `reply_valid`: grant reply and decrement credit. When credit reaches 0 → `TURN_REQ`, credit = `REQ_WEIGHT`.
  - Else if `req_valid`: grant request, go to `TURN_REQ`, credit = `REQ_WEIGHT - 1`. If that value is 0 → `TURN_REPLY`, credit = `REPLY_WEIGHT`.
- `TURN_REQ` is symmetric, with the sources and weights swapped.
- Neither source valid, or no slot: state and credit hold.
- At most one `*_ready` per cycle: `*_ready = slot && granted`. The handshake completes in the same cycle.
- Age counters (16-bit, one per source):
  - Clear when the source is granted or `!valid`.
  - Otherwise increment each cycle, saturating at 65535.
- `tx_pause` (registered) = either age ≥ `PAUSE_THRESH`. It deasserts the cycle after the aged source is granted or drops valid.

## Timing
- Reset values:
  - state `TURN_REPLY`, credit = `REPLY_WEIGHT`, ages 0.
  - `ipg_chunk` 0, `ipg_chunk_valid` 0, `ipg_chunk_src` 0, `tx_pause` 0.
  - `*_ready` is 0 while `rst` is high.
- Latency: slot at cycle N → `ipg_chunk`/`ipg_chunk_valid`/`ipg_chunk_src` at N+1. The downstream mux delays the block by one register to align.
- `ipg_chunk_valid` is a single-cycle pulse per grant. It is 0 in cycles without a grant, and the chunk/src registers hold their last value.
- Back-to-back slots yield back-to-back grants, up to 100% slot utilisation.
- Reset mid-operation: all state clears asynchronously. A grant being registered in the reset cycle is dropped. The queue has already popped it, which is accepted loss.
- Source drops valid while holding its turn: the credit is not consumed and the other source is served on that slot.

## Configuration
- `IPG_SLOT_SCHED_STATS_EN` defined adds these ports:
  - `stat_slots` (32 b): slots seen.
  - `stat_reply_grants` (32 b) and `stat_req_grants` (32 b): grants per source.
  - `stat_wasted` (32 b): slots with no valid source.
  - All counters wrap and reset to 0.
- Undefined: these ports and their counters are absent. Scheduling behaviour is identical either way.

## Structure
- Shared package `ipg_pkg`:
  - `IDLE_BLOCK_TYPE = 8'h1E`, `CTRL_HDR = 2'b10`.
  - `typedef enum {TURN_REPLY, TURN_REQ} ipg_turn_t`.
  - `ipg_src_t` (0 = reply, 1 = request).
- One sub-module, `ipg_wait_age`: saturating age counter plus threshold compare, instantiated twice.

## Test plan
- Both sources always valid, every block idle (hdr 10, type 1E), weights 3/1 → grant source pattern repeats R,R,R,Q. `ipg_chunk_valid` is high continuously from cycle 2 after reset release.
- Data blocks only (hdr 01) for 100 cycles with `reply_valid`=1, `PAUSE_THRESH`=64 → no `reply_ready`. `tx_pause` rises at cycle 65 and falls one cycle after the first idle block is granted.
- Only `req_valid`=1 in `TURN_REPLY` → request granted on every slot, and the FSM alternates correctly without stalling.
- A control block with type 0x33 (start) → not a slot: no ready, no `ipg_chunk_valid`.
- Assert `rst` mid-stream while both queues are valid → all outputs 0 immediately. After release the first grant is reply, with credit = `REPLY_WEIGHT`.
- With `IPG_SLOT_SCHED_STATS_EN`: 10 slots, 4 reply grants, 3 request grants → `stat_slots`=10, `stat_reply_grants`=4, `stat_req_grants`=3, `stat_wasted`=3.
